// File: rtl/axis_n_arb_mux.sv
// N-channel AXI-Stream packet merge: round-robin arbitration, grant held for a
// whole packet, output served from a 2-entry buffer so input ready never sees m_axis_tready.
module axis_n_arb_mux #(
  parameter  int N_CH   = 16,
  parameter  int DATA_W = 32,
  localparam int GW     = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_CH-1:0]        select_in,
  input  logic [N_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [N_CH-1:0]        s_axis_tvalid,
  input  logic [N_CH-1:0]        s_axis_tlast,
  output logic [N_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [GW-1:0]          grant_out,
  output logic                   busy_out
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q;
  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   grant_q;
  logic            busy_q;
  logic [N_CH-1:0] sel_q;
  logic [1:0]      cnt_q, cnt_d;
  logic            rd_q, wr_q;
  logic [DATA_W:0] buf_q [2];

  logic [DATA_W-1:0] ch_data [N_CH];
  logic [N_CH-1:0]   cand;
  logic              found;
  logic [GW-1:0]     pick, idx;
  logic              in_rdy, push, pop, in_last;

  for (genvar i = 0; i < N_CH; i++) begin : g_split
    assign ch_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
  end

  assign cand = sel_q & s_axis_tvalid;

  // First candidate after the last finished grant, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = GW'((int'(ptr_q) + k) % N_CH);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign in_rdy  = (state_q == LOCKED) && (cnt_q != 2'd2);
  assign push    = in_rdy && s_axis_tvalid[grant_q];
  assign in_last = s_axis_tlast[grant_q];
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign cnt_d   = cnt_q + 2'(push) - 2'(pop);

  always_comb begin
    s_axis_tready = '0;
    if (in_rdy) s_axis_tready[grant_q] = 1'b1;
  end

  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign {m_axis_tlast, m_axis_tdata} = buf_q[rd_q];
  assign grant_out = grant_q;
  assign busy_out  = busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= GW'(N_CH - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (found) begin
        grant_q <= pick;
        busy_q  <= 1'b1;
        state_q <= LOCKED;
      end
    end else if (push && in_last) begin
      ptr_q   <= grant_q;
      busy_q  <= 1'b0;
      state_q <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q    <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      sel_q <= select_in;
      cnt_q <= cnt_d;
      if (push) begin
        buf_q[wr_q] <= {in_last, ch_data[grant_q]};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
    end
  end

endmodule

// File: tb/tb_axis_n_arb_mux.sv
// Bench for axis_n_arb_mux: per-channel packet sources, a transaction-level
// expected-output queue, directed scenario table and randomized runs.
module tb_axis_n_arb_mux;
  localparam int N  = 16;
  localparam int DW = 16;
  localparam int GW = 4;

  typedef logic [DW:0] beat_t;
  typedef struct packed {
    logic [15:0] mask;
    logic [15:0] src;
    logic [7:0]  len;
    logic [7:0]  npk;
    logic [7:0]  nseq;
    logic [31:0] seq;
  } row_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    select_in;
  logic [N*DW-1:0] s_tdata;
  logic [DW-1:0]   s_dat [N];
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tlast, m_tready;
  logic [GW-1:0]   grant_out;
  logic            busy_out;

  axis_n_arb_mux #(.N_CH(N), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .select_in(select_in),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .grant_out(grant_out), .busy_out(busy_out)
  );

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign s_tdata[i*DW +: DW] = s_dat[i];
  end

  always #5 clk = ~clk;

  beat_t srcq [N][$];
  beat_t expq [$];
  row_t  tbl  [4];
  int    checks, failures;
  int    cyc, acc_cnt, outstanding, max_out, last_acc, last_out, mrdy_mode;
  bit    acc_seen, out_seen, prev_in_last, prev_out_last, chk_timing, gap_en;
  int    mid [N];
  int    np [N];
  int    ln [N][4];
  int    pc [N];
  logic [15:0] rmask;
  logic [31:0] sq;
  int    g, n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t mkbeat(input int ch, input int p, input int b, input bit last);
    logic [3:0] c4, p4;
    logic [7:0] by;
    c4 = ch[3:0];
    p4 = p[3:0];
    by = 8'(8'hA0 + b);
    return {last, c4, p4, by};
  endfunction

  task automatic push_pkt(input int ch, input int p, input int len);
    for (int b = 0; b < len; b++) srcq[ch].push_back(mkbeat(ch, p, b, b == len - 1));
  endtask

  task automatic exp_pkt(input int ch, input int p, input int len);
    for (int b = 0; b < len; b++) expq.push_back(mkbeat(ch, p, b, b == len - 1));
  endtask

  task automatic drive_inputs();
    beat_t b;
    for (int ch = 0; ch < N; ch++) begin
      if (srcq[ch].size() > 0 && !(gap_en && mid[ch] != 0 && $urandom_range(0, 3) == 0)) begin
        b = srcq[ch][0];
        s_tvalid[ch] = 1'b1;
        s_tlast[ch]  = b[DW];
        s_dat[ch]    = b[DW-1:0];
      end else begin
        s_tvalid[ch] = 1'b0;
        s_tlast[ch]  = 1'b0;
        s_dat[ch]    = '0;
      end
    end
    case (mrdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic reset_model();
    for (int ch = 0; ch < N; ch++) begin
      srcq[ch].delete();
      mid[ch] = 0;
    end
    expq.delete();
    outstanding = 0;
    acc_cnt = 0;
    max_out = 0;
    acc_seen = 0;
    out_seen = 0;
    select_in = '0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    reset_model();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // One clock: sample at negedge, account handshakes after posedge, drive next inputs.
  task automatic tick();
    logic [N-1:0] acc;
    logic ofire;
    beat_t od, b, e;
    int mc;
    bit ok;
    @(negedge clk);
    acc   = s_tvalid & s_tready;
    ofire = m_tvalid & m_tready;
    od    = {m_tlast, m_tdata};
    mc    = outstanding;
    if (mc > max_out) max_out = mc;
    ok = $onehot0(s_tready) && (mc <= 2) && (m_tvalid == (mc != 0));
    if (mc == 2 && s_tready != '0) ok = 0;
    if (!busy_out && s_tready != '0) ok = 0;
    if (busy_out && mc < 2 && !$onehot(s_tready)) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hs_inv: ready=0x%0h m_valid=%b busy=%b, required consistent with %0d buffered beats (t=%0t)",
               s_tready, m_tvalid, busy_out, mc, $time);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int ch = 0; ch < N; ch++) begin
      if (acc[ch] && srcq[ch].size() > 0) begin
        b = srcq[ch].pop_front();
        if (chk_timing && acc_seen) chk("in_gap", cyc - last_acc, prev_in_last ? 2 : 1);
        acc_seen = 1;
        last_acc = cyc;
        prev_in_last = b[DW];
        mid[ch] = b[DW] ? 0 : 1;
        acc_cnt++;
        outstanding++;
      end
    end
    if (ofire) begin
      outstanding--;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_extra: got beat 0x%0h, expected no beat (t=%0t)", od, $time);
      end else begin
        e = expq.pop_front();
        chk("out_beat", od, e);
      end
      if (chk_timing && out_seen && !prev_out_last) chk("out_gap", cyc - last_out, 1);
      out_seen = 1;
      last_out = cyc;
      prev_out_last = od[DW];
    end
    drive_inputs();
  endtask

  task automatic run_drain(input string nm, input int budget);
    int k;
    k = 0;
    while (expq.size() > 0 && k < budget) begin
      tick();
      k++;
    end
    chk(nm, expq.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    gap_en = 0; mrdy_mode = 0; chk_timing = 0;
    tbl[0] = '{mask:16'h0004, src:16'h0004, len:8'd4, npk:8'd1, nseq:8'd1, seq:32'h00000002};
    tbl[1] = '{mask:16'h000B, src:16'h000F, len:8'd2, npk:8'd2, nseq:8'd6, seq:32'h00310310};
    tbl[2] = '{mask:16'h8001, src:16'h8003, len:8'd1, npk:8'd2, nseq:8'd4, seq:32'h0000F0F0};
    tbl[3] = '{mask:16'h0030, src:16'h0030, len:8'd3, npk:8'd2, nseq:8'd4, seq:32'h00005454};

    rstn = 1'b0;
    reset_model();
    drive_inputs();
    @(posedge clk);
    #1;
    chk("rst_m_valid", m_tvalid, 0);
    chk("rst_m_data", {m_tlast, m_tdata}, 0);
    chk("rst_s_ready", s_tready, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_grant", grant_out, 0);

    // Directed scenarios: expected grant order is written out per row.
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      mrdy_mode = 0; gap_en = 0; chk_timing = 1;
      for (int ch = 0; ch < N; ch++) begin
        pc[ch] = 0;
        if (tbl[r].src[ch])
          for (int p = 0; p < int'(tbl[r].npk); p++) push_pkt(ch, p, int'(tbl[r].len));
      end
      sq = tbl[r].seq;
      g = 0;
      for (int k = 0; k < int'(tbl[r].nseq); k++) begin
        g = int'(sq[k*4 +: 4]);
        exp_pkt(g, pc[g], int'(tbl[r].len));
        pc[g]++;
      end
      select_in = tbl[r].mask;
      drive_inputs();
      run_drain("row_drain", 400);
      repeat (4) tick();
      chk("row_grant_hold", grant_out, g);
      chk("row_idle", busy_out, 0);
      chk_timing = 0;
    end

    // Backpressure with m_axis_tready pattern 1,0,0,1.
    apply_reset();
    mrdy_mode = 1;
    push_pkt(0, 0, 6);
    exp_pkt(0, 0, 6);
    select_in = 16'h0001;
    drive_inputs();
    run_drain("bp_drain", 200);
    chk("bp_full_reached", max_out, 2);
    mrdy_mode = 0;

    // Channel removed from the mask mid-packet still finishes it.
    apply_reset();
    push_pkt(1, 0, 5);
    push_pkt(1, 1, 5);
    exp_pkt(1, 0, 5);
    select_in = 16'h0002;
    drive_inputs();
    n = 0;
    while (expq.size() > 0 && n < 200) begin
      tick();
      n++;
      if (acc_cnt >= 2) select_in = '0;
    end
    chk("mask_chg_drain", expq.size(), 0);
    repeat (20) tick();
    chk("mask_chg_untouched", srcq[1].size(), 5);
    chk("mask_chg_idle", busy_out, 0);

    // Reset during beat 3 of channel 1, after channel 0 already won once.
    apply_reset();
    push_pkt(0, 0, 2);
    push_pkt(1, 0, 5);
    exp_pkt(0, 0, 2);
    exp_pkt(1, 0, 5);
    select_in = 16'h0003;
    drive_inputs();
    n = 0;
    while (acc_cnt < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_mid_reach", acc_cnt, 5);
    rstn = 1'b0;
    #1;
    chk("rst_mid_outputs", {m_tvalid, m_tlast, m_tdata, busy_out, s_tready, grant_out}, 0);
    reset_model();
    push_pkt(0, 1, 2);
    push_pkt(1, 1, 2);
    exp_pkt(0, 1, 2);
    exp_pkt(1, 1, 2);
    select_in = 16'h0003;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run_drain("rst_mid_drain", 200);

    // Empty mask with every channel valid.
    apply_reset();
    for (int ch = 0; ch < N; ch++) push_pkt(ch, 0, 1);
    drive_inputs();
    repeat (20) begin
      tick();
      chk("empty_mask", {busy_out, m_tvalid, |s_tready}, 0);
    end

    // Randomized: random mask, packet counts/lengths, valid gaps, output stalls.
    for (int run = 0; run < 4; run++) begin
      apply_reset();
      gap_en = 1;
      mrdy_mode = 2;
      rmask = 16'($urandom_range(1, 65535));
      for (int ch = 0; ch < N; ch++) begin
        np[ch] = int'($urandom_range(0, 3));
        for (int p = 0; p < np[ch]; p++) begin
          ln[ch][p] = int'($urandom_range(1, 4));
          push_pkt(ch, p, ln[ch][p]);
        end
      end
      for (int r = 0; r < 3; r++)
        for (int ch = 0; ch < N; ch++)
          if (rmask[ch] && r < np[ch]) exp_pkt(ch, r, ln[ch][r]);
      select_in = rmask;
      drive_inputs();
      run_drain("rand_drain", 3000);
      repeat (6) tick();
      chk("rand_idle", busy_out, 0);
      gap_en = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_n_arb_mux.md
# axis_n_arb_mux

Parametrised N-channel AXI-Stream packet multiplexer. It merges up to N_CH ADC-driver streams into the single PS-bound stream. Unlike the earlier combinational one-hot mux, it does three things: arbitrates round-robin among all enabled channels, holds a grant for a whole packet (until tlast), and drives the output from a 2-entry buffer so there is no combinational path from m_axis_tready to s_axis_tready.

## Interface
- N_CH, 16, number of input channels (2..32)
- DATA_W, ps_axis_width, tdata width per channel
- GW, $clog2(N_CH), grant index width (derived, not overridable)

- clk  in  1  single clock; all logic on its rising edge
- rstn  in  1  asynchronous active-low reset
- select_in  in  N_CH  channel enable mask; any number of bits may be set
- s_axis_tdata  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- s_axis_tvalid  in  N_CH  per-channel valid
- s_axis_tlast  in  N_CH  per-channel end of packet
- s_axis_tready  out  N_CH  per-channel ready; at most one bit high
- m_axis_tdata  out  DATA_W  output data
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output end of packet
- m_axis_tready  in  1  output ready
- grant_out  out  GW  currently or last granted channel
- busy_out  out  1  high while a packet is locked

## Operation
- select_in is registered once into select_int. Only select_int is used internally.
- FSM states:
  - IDLE: busy_out=0, all s_axis_tready=0.
    - Candidates are select_int & s_axis_tvalid.
    - If any candidate exists, search from (ptr+1) mod N_CH upward with wrap and pick the first hit g.
    - Register grant=g and go to LOCKED.
    - With no candidates, stay in IDLE.
  - LOCKED: busy_out=1; s_axis_tready[grant] = (fifo_cnt != 2); all other ready bits are 0.
    - Each accepted beat (valid & ready on channel grant) is pushed with its tdata and tlast.
    - An accepted beat with tlast=1 sets ptr=grant and returns to IDLE on the next cycle.
- Mask changes during LOCKED do not break the packet. A channel removed mid-packet still completes its packet.
- If select_int==0, no new grant is issued. Output drains normally.
- Output buffer:
  - 2-entry FIFO holding {tlast, tdata}, with fifo_cnt in 0..2.
  - The head drives m_axis_*; m_axis_tvalid = (fifo_cnt != 0).
  - Pop on m_axis_tvalid & m_axis_tready. Push and pop may happen in the same cycle, leaving the count unchanged.
  - Ready depends only on registered state (state, grant, fifo_cnt).
- grant_out holds the last grant after returning to IDLE.
- Reset values (rstn=0, asynchronous):
  - state=IDLE, ptr=N_CH-1 (so channel 0 has first priority), grant=0.
  - select_int=0, fifo_cnt=0.
  - All outputs 0 (m_axis_tvalid=0, s_axis_tready=0, busy_out=0, grant_out=0).
- Reset mid-packet flushes the FIFO. The remainder of the packet is lost; no recovery is required.

## Timing
- select_in to effect: 1 cycle (registered).
- IDLE decision to s_axis_tready high: 1 cycle (grant registered).
- Accepted beat to m_axis_tvalid: 1 cycle.
- Streaming throughput with m_axis_tready held at 1: one beat per cycle.
- Packet boundary cost: exactly one cycle with no input acceptance (the IDLE cycle), including when the same channel re-wins.
- Backpressure:
  - m_axis_tready low with fifo_cnt=2 drops s_axis_tready in the same cycle the count reaches 2, i.e. ready is already low on the following edge.
  - No beat is ever lost or duplicated.
- Single-beat packet (tvalid & tlast on the first beat): LOCKED lasts one accepting cycle.

## Test plan
- Single channel: select_in=0x0004, channel 2 sends a 4-beat packet 0xA0..0xA3 with tlast on the last beat, m_axis_tready=1.
  - Output is A0..A3 on consecutive cycles with tlast on A3; grant_out=2.
  - Other channels' ready stays 0.
- Round-robin: mask=0x000B, channels 0, 1 and 3 continuously valid, each sending 2-beat packets.
  - Grant order is 0,1,3,0,1,3.
  - Each packet is contiguous on the output, with one input bubble between packets.
- Backpressure: a 6-beat packet with m_axis_tready toggling 1,0,0,1,...
  - fifo_cnt never exceeds 2 and s_axis_tready falls when it reaches 2.
  - The output sequence is exact, with no drops or duplicates.
- Mask change mid-packet: clear channel 1 from select_in at beat 2 of its 5-beat packet.
  - All 5 beats are delivered and channel 1 is not granted afterwards.
- Reset mid-packet: assert rstn=0 during beat 3.
  - Outputs are 0 immediately; after release the first grant goes to channel 0 if it is valid and enabled.
- Empty mask: select_in=0 with all channels valid.
  - No ready asserted, m_axis_tvalid stays 0, busy_out=0.
